apb_alu_requester: RTL
======================

Name: apb_alu_requester

Overview:
- APB initiator that drives one complete ALU job on the APB ALU device: write operand A, write operand B, write control/opcode, read result.
- Accepts a job on a valid/ready request port and returns the result on a valid/ready response port.
- Sits between a local command source and the device's APB slave port, replacing hand-sequenced master writes.
- Adds PREADY wait-state handling and a per-transfer timeout.

Parameters:
- BASE_ADDR, 32'h0, device base address; register offsets are added to it.
- DATA_W, 32, APB data width and operand/result width.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; legal range ≥1.

Ports:
- PCLK  in  1  clock, all logic on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- req_valid  in  1  job request valid.
- req_ready  out  1  requester can accept a job.
- req_op_a  in  DATA_W  operand A.
- req_op_b  in  DATA_W  operand B.
- req_op  in  2  opcode: 1 = AND, 2 = OR, 3 = XOR, 0 = NOP (still written).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  result read from the RESULT register.
- rsp_err  out  1  job aborted on timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  1 = write, 0 = read.
- PADDR  out  32  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  slave ready.

Behaviour:
- Reset (async assert, sync release): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1.
- Register offsets: OPA=0x0, OPB=0x4, RESULT=0x8, CTRL=0xC.
- Transfer order per job, step 0..3:
  - step 0: write OPA ← op_a.
  - step 1: write OPB ← op_b.
  - step 2: write CTRL ← zero-extended req_op.
  - step 3: read RESULT.
- req_op_a, req_op_b and req_op are captured into internal registers on acceptance (req_valid && req_ready).
- req_ready=1 only in IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on acceptance go to SETUP with step=0.
- SETUP, exactly 1 cycle: PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA valid for the current step. Then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA held stable.
  - On the edge with PREADY=1: the step completes; on step 3, PRDATA is captured into rsp_data.
  - If step<3: step++ and go to SETUP. Back-to-back transfers, no idle cycle between them.
  - If step==3: go to RESP with rsp_err=0.
- Timeout: a wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT: drop PSEL/PENABLE, rsp_data=0, rsp_err=1, go to RESP.
  - Remaining steps are skipped.
- RESP: rsp_valid=1; PSEL=0, PENABLE=0. Hold rsp_data and rsp_err until rsp_valid && rsp_ready, then go to IDLE and clear rsp_valid.
- req_ready rises in the cycle after the handshake; there is no same-cycle re-accept.
- Latency with zero wait states: acceptance edge → 8 APB cycles → rsp_valid high in the 9th cycle.
- Each wait state adds 1 cycle.
- PWDATA outside write SETUP/ACCESS holds its last value; it is don't-care for the bench.
- PADDR returns to BASE_ADDR in IDLE.
- PRESETn asserted mid-job: immediate return to reset values. The job is lost and no response is issued.
- req_valid while busy: ignored, not accepted, since req_ready=0.
- rsp_ready high before rsp_valid: no effect.

Decomposition:
- Package apb_alu_pkg: register offset constants (OPA, OPB, RESULT, CTRL), opcode constants (NOP, AND, OR, XOR), FSM state enum, step type (2-bit).
- Sub-module apb_xfer_engine: single SETUP/ACCESS transfer with PREADY wait and timeout counter.
  - Inputs: start, addr, write, wdata.
  - Outputs: done, err, rdata.
- The top-level module sequences the steps and owns the request/response handshakes.

Test Plan:
- Job A=3, B=7, op=1, zero-wait slave → writes 0x0=3, 0x4=7, 0xC=1, read 0x8; rsp_data=3, rsp_err=0, rsp_valid exactly 9 cycles after acceptance.
- Job A=0xA, B=4, op=2, slave holds PREADY low 2 cycles on every transfer → rsp_data=0xE; latency 17 cycles; PADDR, PWDATA and PWRITE stable through every wait.
- Job A=9, B=3, op=3, rsp_ready held low 5 cycles → rsp_data=0xA; rsp_valid, rsp_data and rsp_err held; req_ready=0 until the handshake.
- TIMEOUT=16, slave never asserts PREADY on the CTRL write → abort after 16 ACCESS cycles; rsp_err=1, rsp_data=0; RESULT is never read.
- PRESETn pulsed low during the OPB ACCESS phase → all outputs reach reset values immediately; no rsp_valid; a new job A=1, B=1, op=1 then returns 1.
- Two jobs with req_valid held continuously → second job accepted only after the first response handshake; no PSEL overlap.

Source files
------------

// File: rtl/apb_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_alu_pkg
// Description : Shared definitions for the APB ALU requester.
//               - Register offsets of the APB ALU device
//               - Opcode encodings
//               - Sequencer FSM state encoding
//               - Job step type, plus a helper that maps a step to its
//                 register offset
// Revision    : 1.0 - initial release
// ============================================================================
package apb_alu_pkg;

    // Register map of the APB ALU device (offsets from its base address)
    localparam logic [31:0] c_REG_OPA    = 32'h0000_0000;
    localparam logic [31:0] c_REG_OPB    = 32'h0000_0004;
    localparam logic [31:0] c_REG_RESULT = 32'h0000_0008;
    localparam logic [31:0] c_REG_CTRL   = 32'h0000_000C;

    // Opcodes written to CTRL
    localparam logic [1:0] c_OP_NOP = 2'd0;
    localparam logic [1:0] c_OP_AND = 2'd1;
    localparam logic [1:0] c_OP_OR  = 2'd2;
    localparam logic [1:0] c_OP_XOR = 2'd3;

    // FSM state encoding (the transfer engine uses the first three)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Job step: one APB transfer per step
    typedef logic [1:0] step_t;

    localparam step_t c_STEP_OPA  = 2'd0;
    localparam step_t c_STEP_OPB  = 2'd1;
    localparam step_t c_STEP_CTRL = 2'd2;
    localparam step_t c_STEP_RES  = 2'd3;

    // Register offset targeted by a given step
    function automatic logic [31:0] step_offset(input step_t i_step);
        logic [31:0] w_ofs;
        case (i_step)
            c_STEP_OPA:  w_ofs = c_REG_OPA;
            c_STEP_OPB:  w_ofs = c_REG_OPB;
            c_STEP_CTRL: w_ofs = c_REG_CTRL;
            default:     w_ofs = c_REG_RESULT;
        endcase
        return w_ofs;
    endfunction

endpackage : apb_alu_pkg
`default_nettype wire

// File: rtl/apb_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : apb_xfer_engine
// Description : Performs a single APB transfer (SETUP then ACCESS) with
//               PREADY wait states and an ACCESS-phase timeout.
//
//               Ports
//                 PCLK, PRESETn     - clock, async active-low reset
//                 i_start           - load a transfer (legal in idle, or in
//                                     the completing ACCESS cycle for
//                                     back-to-back chaining)
//                 i_addr, i_write,
//                 i_wdata           - transfer attributes for the load
//                 o_done            - ACCESS cycle with PREADY high
//                 o_err             - ACCESS timed out this cycle
//                 o_rdata           - read data (valid with o_done)
//                 PSEL..PWDATA      - registered APB master outputs
//                 PRDATA, PREADY    - APB slave responses
// Revision    : 1.0 - initial release
// ============================================================================
module apb_xfer_engine
    import apb_alu_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          TIMEOUT   = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              i_start,
    input  logic [31:0]       i_addr,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    // Counter runs 0..TIMEOUT-1; the ACCESS cycle that sees TIMEOUT-1 with
    // PREADY still low is the TIMEOUT-th wait cycle and aborts.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_WAIT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    state_e           r_phase;
    logic [CNT_W-1:0] r_wait;

    logic w_in_access;
    logic w_load;

    assign w_in_access = (r_phase == ST_ACCESS);
    assign o_done      = w_in_access && PREADY;
    assign o_err       = w_in_access && !PREADY && (r_wait == c_WAIT_LIMIT);
    assign o_rdata     = PRDATA;

    // A start in the completing ACCESS cycle goes straight to the next
    // SETUP, giving back-to-back transfers with no idle cycle.
    assign w_load = i_start && ((r_phase == ST_IDLE) || o_done);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_phase <= ST_IDLE;
            r_wait  <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= 32'h0;
            PWDATA  <= '0;
        end else if (w_load) begin
            r_phase <= ST_SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= i_addr;
            PWRITE  <= i_write;
            if (i_write) begin
                PWDATA <= i_wdata;
            end
        end else begin
            case (r_phase)
                ST_SETUP: begin
                    r_phase <= ST_ACCESS;
                    PENABLE <= 1'b1;
                    r_wait  <= '0;
                end
                ST_ACCESS: begin
                    if (o_done || o_err) begin
                        r_phase <= ST_IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        PADDR   <= BASE_ADDR;
                    end else begin
                        r_wait <= r_wait + c_ONE;
                    end
                end
                default: begin
                    r_phase <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : apb_xfer_engine
`default_nettype wire

// File: rtl/apb_alu_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb_alu_requester
// Description : APB initiator running one ALU job per request:
//               write OPA, write OPB, write CTRL, read RESULT.
//
//               Ports
//                 PCLK, PRESETn              - clock, async active-low reset
//                 req_valid/req_ready        - job request handshake
//                 req_op_a, req_op_b, req_op - job operands and opcode
//                 rsp_valid/rsp_ready        - response handshake
//                 rsp_data, rsp_err          - result / timeout flag
//                 PSEL..PWDATA, PRDATA,
//                 PREADY                     - APB master interface
// Revision    : 1.0 - initial release
// ============================================================================
module apb_alu_requester
    import apb_alu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DATA_W    = 32,
    parameter int          TIMEOUT   = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_op_a,
    input  logic [DATA_W-1:0] req_op_b,
    input  logic [1:0]        req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    state_e            r_state;
    step_t             r_step;
    logic [DATA_W-1:0] r_op_b;
    logic [1:0]        r_op;

    logic              w_accept;
    logic              w_advance;
    logic              w_start;
    step_t             w_next_step;
    logic [31:0]       w_addr;
    logic              w_write;
    logic [DATA_W-1:0] w_wdata;
    logic              w_done;
    logic              w_err;
    logic [DATA_W-1:0] w_rdata;

    assign w_accept  = req_valid && req_ready;
    assign w_advance = (r_state == ST_ACCESS) && w_done && (r_step != c_STEP_RES);
    assign w_start   = w_accept || w_advance;

    assign w_next_step = (r_state == ST_IDLE) ? c_STEP_OPA : (r_step + 2'd1);
    assign w_addr      = BASE_ADDR + step_offset(w_next_step);
    assign w_write     = (w_next_step != c_STEP_RES);

    // Operand A is issued on the acceptance edge itself, so it is taken
    // straight from the request port; the engine's PWDATA register holds it.
    always_comb begin
        w_wdata = '0;
        case (w_next_step)
            c_STEP_OPA:  w_wdata = req_op_a;
            c_STEP_OPB:  w_wdata = r_op_b;
            c_STEP_CTRL: w_wdata = {{(DATA_W-2){1'b0}}, r_op};
            default:     w_wdata = '0;
        endcase
    end

    apb_xfer_engine #(
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE_ADDR),
        .TIMEOUT   (TIMEOUT)
    ) u_xfer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .i_start (w_start),
        .i_addr  (w_addr),
        .i_write (w_write),
        .i_wdata (w_wdata),
        .o_done  (w_done),
        .o_err   (w_err),
        .o_rdata (w_rdata),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    // Job sequencer; SETUP/ACCESS run in lockstep with the transfer engine.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= ST_IDLE;
            r_step    <= c_STEP_OPA;
            r_op_b    <= '0;
            r_op      <= 2'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_b    <= req_op_b;
                        r_op      <= req_op;
                        r_step    <= c_STEP_OPA;
                        req_ready <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        if (r_step == c_STEP_RES) begin
                            rsp_data  <= w_rdata;
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            r_state   <= ST_RESP;
                        end else begin
                            r_step  <= w_next_step;
                            r_state <= ST_SETUP;
                        end
                    end else if (w_err) begin
                        // Remaining steps are abandoned on timeout
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : apb_alu_requester
`default_nettype wire
